raster_cmd_scheduler: RTL and testbench

Command queue and sequencer between the CPU and the rasterizer. It buffers up to DEPTH draw commands from the CPU and issues them one at a time to the rasterizer over an execute_request/busy handshake. Issue can optionally be gated to vertical blanking so framebuffer writes do not tear the scan-out. The block sits beside the rasterizer in vgacpu_top, clocked from clk_50.

---
 rtl/common.sv | 37 +++
 rtl/raster_cmd_fifo.sv | 66 ++++++
 rtl/raster_cmd_scheduler.sv | 107 ++++++++++
 tb/tb_raster_cmd_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types for the raster path: command encoding, the queued command entry,
// framebuffer geometry and the scheduler FSM state.
package common;

  typedef enum logic [2:0] {
    CmdNop   = 3'd0,
    CmdClear = 3'd1,
    CmdFill  = 3'd2,
    CmdLine  = 3'd3,
    CmdRect  = 3'd4,
    CmdPixel = 3'd5
  } raster_command_t;

  typedef struct packed {
    raster_command_t command;
    logic [2:0]      colour;
    logic [7:0]      x0;
    logic [7:0]      y0;
    logic [7:0]      x1;
    logic [7:0]      y1;
  } raster_cmd_entry_t;

  localparam int unsigned FB_WIDTH  = 214;
  localparam int unsigned FB_HEIGHT = 160;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } sched_state_t;

  // Saturate a coordinate to the last visible pixel.
  function automatic logic [7:0] clamp_coord(input logic [7:0] value, input logic [7:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/raster_cmd_fifo.sv
// Synchronous circular-buffer FIFO with flush.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (ignored when full or flushing)
//   pop_i        : advance past the head (ignored when empty or flushing)
//   flush_i      : drop all stored entries in one cycle
//   rdata_o      : current head entry
//   count_o      : number of stored entries (registered)
//   full_o       : count_o == Depth
//   empty_o      : count_o == 0
module raster_cmd_fifo #(
  parameter int unsigned Depth   = 8,
  parameter type         entry_t = logic [7:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  entry_t                     wdata_i,
  output entry_t                     rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= wptr_q;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/raster_cmd_scheduler.sv
// Draw-command queue and sequencer between the CPU and the rasterizer.
// Buffers up to DEPTH commands and issues them one at a time over an
// execute_request / raster_busy handshake, optionally only during vblank.
//   clk, rst        : 50 MHz clock, synchronous active-high reset
//   cmd_valid/ready : CPU push handshake, cmd_in is the offered command
//   flush           : discard every queued, not yet issued command
//   vblank          : vertical blanking (gates issue when VBLANK_GATE != 0)
//   raster_busy     : rasterizer is executing
//   raster_cmd      : command presented to the rasterizer (held from pop to pop)
//   execute_request : start request to the rasterizer
//   queue_count     : occupied entries
//   idle            : queue empty and nothing in flight (registered)
module raster_cmd_scheduler
  import common::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned VBLANK_GATE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  raster_cmd_entry_t          cmd_in,
  input  logic                       flush,
  input  logic                       vblank,
  input  logic                       raster_busy,
  output raster_cmd_entry_t          raster_cmd,
  output logic                       execute_request,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       idle
);

  localparam logic [7:0] XMax = 8'(FB_WIDTH - 1);
  localparam logic [7:0] YMax = 8'(FB_HEIGHT - 1);

  sched_state_t      state_q, state_d;
  raster_cmd_entry_t raster_cmd_q;
  logic              exec_q;
  logic              idle_q;

  raster_cmd_entry_t clamped;
  raster_cmd_entry_t fifo_head;
  logic              fifo_full, fifo_empty;
  logic              push, pop, gate_open;

  // No look-ahead on a same-cycle pop: a full queue always refuses.
  assign cmd_ready = !fifo_full && !flush && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign gate_open = (VBLANK_GATE == 0) || vblank;
  // flush beats a pending pop so the head is discarded rather than issued.
  assign pop       = (state_q == IDLE) && !fifo_empty && gate_open && !flush;

  always_comb begin
    clamped    = cmd_in;
    clamped.x0 = clamp_coord(cmd_in.x0, XMax);
    clamped.y0 = clamp_coord(cmd_in.y0, YMax);
    clamped.x1 = clamp_coord(cmd_in.x1, XMax);
    clamped.y1 = clamp_coord(cmd_in.y1, YMax);
  end

  raster_cmd_fifo #(
    .Depth   (DEPTH),
    .entry_t (raster_cmd_entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (clamped),
    .rdata_o (fifo_head),
    .count_o (queue_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = REQ;
      REQ:     if (raster_busy) state_d = BUSY;
      BUSY:    if (!raster_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // execute_request trails the REQ state by one register stage: it rises the
  // cycle after the pop and falls the cycle after busy is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      raster_cmd_q <= '0;
      exec_q       <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      if (pop) raster_cmd_q <= fifo_head;
      exec_q  <= (state_q == REQ);
      idle_q  <= (state_q == IDLE) && fifo_empty;
    end
  end

  assign raster_cmd      = raster_cmd_q;
  assign execute_request = exec_q;
  assign idle            = idle_q;

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
module tb_raster_cmd_scheduler;
  import common::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic              rst, cmd_valid, cmd_ready, flush, vblank, raster_busy;
  logic              execute_request, idle;
  raster_cmd_entry_t cmd_in, raster_cmd;
  logic [3:0]        queue_count;

  logic              g_valid, g_ready, g_flush, g_vblank, g_busy, g_exec, g_idle;
  raster_cmd_entry_t g_cmd_in, g_raster_cmd;
  logic [3:0]        g_count;

  int n_assert = 0;
  int n_fail   = 0;
  bit saw_exec;

  raster_cmd_scheduler #(.DEPTH(8), .VBLANK_GATE(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_in          (cmd_in),
    .flush           (flush),
    .vblank          (vblank),
    .raster_busy     (raster_busy),
    .raster_cmd      (raster_cmd),
    .execute_request (execute_request),
    .queue_count     (queue_count),
    .idle            (idle)
  );

  raster_cmd_scheduler #(.DEPTH(8), .VBLANK_GATE(1)) dut_g (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (g_valid),
    .cmd_ready       (g_ready),
    .cmd_in          (g_cmd_in),
    .flush           (g_flush),
    .vblank          (g_vblank),
    .raster_busy     (g_busy),
    .raster_cmd      (g_raster_cmd),
    .execute_request (g_exec),
    .queue_count     (g_count),
    .idle            (g_idle)
  );

  function automatic raster_cmd_entry_t mk(input raster_command_t c, input logic [2:0] col,
                                           input logic [7:0] x0, input logic [7:0] y0,
                                           input logic [7:0] x1, input logic [7:0] y1);
    raster_cmd_entry_t e;
    e.command = c;
    e.colour  = col;
    e.x0      = x0;
    e.y0      = y0;
    e.x1      = x1;
    e.y1      = y1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0; vblank = 1'b0; raster_busy = 1'b0;
    cmd_in = '0;
    g_valid = 1'b0; g_flush = 1'b0; g_vblank = 1'b0; g_busy = 1'b0; g_cmd_in = '0;
    #1;
    check("ready_in_reset", 64'(cmd_ready), 64'd0);
    tick; tick;
    check("reset_exec", 64'(execute_request), 64'd0);
    check("reset_count", 64'(queue_count), 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_raster_cmd", 64'(raster_cmd), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    // Single FILL into an empty queue
    cmd_in = mk(CmdFill, 3'b101, 8'd10, 8'd20, 8'd30, 8'd40);
    cmd_valid = 1'b1;
    tick;                                       // edge N: push
    cmd_valid = 1'b0;
    check("t1_count_after_push", 64'(queue_count), 64'd1);
    tick;                                       // edge N+1: pop
    check("t1_exec_not_yet", 64'(execute_request), 64'd0);
    check("t1_passthrough", 64'(raster_cmd), 64'(mk(CmdFill, 3'b101, 8'd10, 8'd20, 8'd30, 8'd40)));
    tick;                                       // edge N+2
    check("t1_exec_high", 64'(execute_request), 64'd1);
    check("t1_colour", 64'(raster_cmd.colour), 64'd5);
    raster_busy = 1'b1;
    tick;                                       // busy sampled
    check("t1_exec_hold_on_busy_edge", 64'(execute_request), 64'd1);
    tick;
    check("t1_exec_drop", 64'(execute_request), 64'd0);
    repeat (8) tick;
    raster_busy = 1'b0;
    tick;
    check("t1_idle_one_after", 64'(idle), 64'd0);
    tick;
    check("t1_idle_two_after", 64'(idle), 64'd1);

    // Fill the queue while the first command stays in flight
    raster_busy = 1'b1;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_in = mk(CmdLine, 3'd1, 8'(i), 8'd0, 8'd0, 8'd0);
      tick;
    end
    check("t2_count7", 64'(queue_count), 64'd7);
    cmd_in = mk(CmdLine, 3'd1, 8'd8, 8'd0, 8'd0, 8'd0);
    tick;
    check("t2_count8", 64'(queue_count), 64'd8);
    check("t2_ready_full", 64'(cmd_ready), 64'd0);
    repeat (3) tick;
    check("t2_full_holds", 64'(queue_count), 64'd8);
    raster_busy = 1'b0;
    tick;                                       // BUSY -> IDLE
    check("t2_full_until_pop", 64'(queue_count), 64'd8);
    tick;                                       // pop, push refused
    check("t2_count_after_pop", 64'(queue_count), 64'd7);
    check("t2_fifo_order", 64'(raster_cmd.x0), 64'd1);
    check("t2_ready_after_pop", 64'(cmd_ready), 64'd1);
    tick;                                       // held-off push accepted
    check("t2_refill", 64'(queue_count), 64'd8);
    check("t2_exec_in_req", 64'(execute_request), 64'd1);

    // Reset during REQ
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_ready_in_reset", 64'(cmd_ready), 64'd0);
    tick;
    check("t6_exec", 64'(execute_request), 64'd0);
    check("t6_count", 64'(queue_count), 64'd0);
    check("t6_idle", 64'(idle), 64'd1);
    check("t6_raster_cmd", 64'(raster_cmd), 64'd0);
    rst = 1'b0;

    // Clamping, also a normal issue right after reset
    cmd_in = mk(CmdRect, 3'd2, 8'd250, 8'd160, 8'd213, 8'd200);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("t3_clamped", 64'(raster_cmd), 64'(mk(CmdRect, 3'd2, 8'd213, 8'd159, 8'd213, 8'd159)));
    tick;
    check("t3_exec_after_reset", 64'(execute_request), 64'd1);
    raster_busy = 1'b1;
    tick; tick;
    raster_busy = 1'b0;
    tick; tick;
    check("t3_idle", 64'(idle), 64'd1);

    // Flush with one in BUSY and two queued
    cmd_valid = 1'b1;
    cmd_in = mk(CmdFill, 3'd3, 8'd1, 8'd1, 8'd1, 8'd1);
    tick;
    cmd_in = mk(CmdFill, 3'd4, 8'd2, 8'd2, 8'd2, 8'd2);
    tick;
    cmd_in = mk(CmdFill, 3'd6, 8'd3, 8'd3, 8'd3, 8'd3);
    raster_busy = 1'b1;
    tick;
    check("t5_count2", 64'(queue_count), 64'd2);
    flush  = 1'b1;
    cmd_in = mk(CmdFill, 3'd7, 8'd4, 8'd4, 8'd4, 8'd4);
    #1;
    check("t5_ready_on_flush", 64'(cmd_ready), 64'd0);
    tick;
    check("t5_count_flushed", 64'(queue_count), 64'd0);
    flush = 1'b0;
    cmd_valid = 1'b0;
    tick;
    check("t5_push_dropped", 64'(queue_count), 64'd0);
    check("t5_inflight_stable", 64'(raster_cmd.colour), 64'd3);
    check("t5_exec_low_busy", 64'(execute_request), 64'd0);
    raster_busy = 1'b0;
    tick; tick;
    check("t5_idle", 64'(idle), 64'd1);
    repeat (3) tick;
    check("t5_no_issue", 64'(execute_request), 64'd0);

    // Flush in IDLE on the cycle a pop would happen
    cmd_in = mk(CmdPixel, 3'd5, 8'd9, 8'd9, 8'd9, 8'd9);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("t5b_count", 64'(queue_count), 64'd0);
    tick; tick;
    check("t5b_no_exec", 64'(execute_request), 64'd0);
    check("t5b_cmd_unchanged", 64'(raster_cmd.colour), 64'd3);

    // VBLANK-gated instance
    g_cmd_in = mk(CmdLine, 3'd6, 8'd5, 8'd6, 8'd7, 8'd8);
    g_valid = 1'b1;
    tick;
    g_valid = 1'b0;
    saw_exec = 1'b0;
    repeat (100) begin
      tick;
      if (g_exec) saw_exec = 1'b1;
    end
    check("t4_no_exec_outside_vblank", 64'(saw_exec), 64'd0);
    check("t4_count_held", 64'(g_count), 64'd1);
    g_vblank = 1'b1;
    tick;
    check("t4_exec_one_after", 64'(g_exec), 64'd0);
    tick;
    check("t4_exec_two_after", 64'(g_exec), 64'd1);
    g_vblank = 1'b0;
    g_busy = 1'b1;
    tick; tick; tick;
    g_busy = 1'b0;
    tick; tick;
    check("t4_completes_idle", 64'(g_idle), 64'd1);
    check("t4_cmd", 64'(g_raster_cmd), 64'(mk(CmdLine, 3'd6, 8'd5, 8'd6, 8'd7, 8'd8)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
